// File: rtl/moore_pkg.sv
// moore_pkg: shared types and helpers for the table-driven Moore machine.
package moore_pkg;
    typedef enum logic {CFG_NEXT = 1'b0, CFG_OUT = 1'b1} cfg_sel_e;
    localparam int STEP_CNT_W = 16;
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/moore_table.sv
// moore_table: flop-based next-state/output tables with range-checked write port and two read ports.
module moore_table
    import moore_pkg::*;
#(
    parameter int N_STATES = 4,
    parameter int IN_W     = 2,
    parameter int OUT_W    = 1,
    parameter int STATE_W  = 2,
    parameter int ADDR_W   = 4,
    parameter int CFG_W    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic               sel,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [CFG_W-1:0]   data,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [IN_W-1:0]    rd_sym,
    output logic [STATE_W-1:0] nxt_o,
    output logic [OUT_W-1:0]   out_o,
    output logic               wr_err_o
);
    localparam int COLS = 2 ** IN_W;
    localparam logic [STATE_W:0] LIMIT = (STATE_W + 1)'(N_STATES);

    logic [STATE_W-1:0] nxt_q [N_STATES][COLS];
    logic [OUT_W-1:0]   out_q [N_STATES];
    logic [STATE_W-1:0] st_f;
    logic [IN_W-1:0]    sym_f;
    logic               bad;

    assign st_f  = addr[ADDR_W-1:IN_W];
    assign sym_f = addr[IN_W-1:0];
    // a table can never hold an illegal state, so both the row and the stored next state are checked
    assign bad   = ({1'b0, st_f} >= LIMIT) ||
                   (sel == CFG_NEXT && {1'b0, data[STATE_W-1:0]} >= LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < N_STATES; s++) begin
                for (int i = 0; i < COLS; i++) nxt_q[s][i] <= STATE_W'(s);
                out_q[s] <= '0;
            end
        end else if (we && !bad) begin
            if (sel == CFG_NEXT) nxt_q[st_f][sym_f] <= data[STATE_W-1:0];
            else out_q[st_f] <= data[OUT_W-1:0];
        end
    end

    assign nxt_o    = nxt_q[rd_state][rd_sym];
    assign out_o    = out_q[rd_state];
    assign wr_err_o = we && bad;
endmodule

// File: rtl/moore_table_fsm.sv
// moore_table_fsm: run-time programmable Moore machine (state register, load/step priority, sticky err).
// Optional step counter output enabled by defining MOORE_STEP_CNT_EN.
module moore_table_fsm
    import moore_pkg::*;
#(
    parameter int N_STATES    = 4,
    parameter int IN_W        = 2,
    parameter int OUT_W       = 1,
    parameter int RESET_STATE = 0,
    localparam int STATE_W    = clog2_min1(N_STATES),
    localparam int ADDR_W     = STATE_W + IN_W,
    localparam int CFG_W      = (STATE_W > OUT_W) ? STATE_W : OUT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IN_W-1:0]    sw_in,
    input  logic               ctrl_in,
    input  logic               state_ld,
    input  logic [STATE_W-1:0] state_in,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic [STATE_W-1:0] state,
    output logic [OUT_W-1:0]   out,
    output logic               err
`ifdef MOORE_STEP_CNT_EN
    ,output logic [STEP_CNT_W-1:0] step_cnt
`endif
);
    localparam logic [STATE_W:0] LIMIT = (STATE_W + 1)'(N_STATES);

    logic [STATE_W-1:0] state_q, nxt;
    logic               err_q, wr_err, ld_ok;

    moore_table #(
        .N_STATES(N_STATES), .IN_W(IN_W), .OUT_W(OUT_W),
        .STATE_W(STATE_W), .ADDR_W(ADDR_W), .CFG_W(CFG_W)
    ) u_table (
        .clk(clk), .reset_n(reset_n), .we(cfg_we), .sel(cfg_sel),
        .addr(cfg_addr), .data(cfg_data), .rd_state(state_q), .rd_sym(sw_in),
        .nxt_o(nxt), .out_o(out), .wr_err_o(wr_err)
    );

    assign ld_ok = {1'b0, state_in} < LIMIT;

    // a rejected cfg write in the same cycle as a valid load still leaves err set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_W'(RESET_STATE);
            err_q   <= 1'b0;
        end else begin
            if (state_ld) begin
                state_q <= ld_ok ? state_in : state_q;
                err_q   <= !ld_ok;
            end else if (ctrl_in) begin
                state_q <= nxt;
            end
            if (wr_err) err_q <= 1'b1;
        end
    end

`ifdef MOORE_STEP_CNT_EN
    logic [STEP_CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (state_ld) cnt_q <= '0;
        else if (ctrl_in && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign step_cnt = cnt_q;
`endif

    assign state = state_q;
    assign err   = err_q;
endmodule

// File: tb/tb_moore_table_fsm.sv
// tb_moore_table_fsm: vector table, corner sequences and randomized checks against a behavioural model.
module tb_moore_table_fsm;
    localparam int NS = 3;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic [1:0] sw_in = '0, state_in = '0, cfg_data = '0, state;
    logic       ctrl_in = 1'b0, state_ld = 1'b0, cfg_we = 1'b0, cfg_sel = 1'b0, err;
    logic [3:0] cfg_addr = '0;
    logic [0:0] out;
`ifdef MOORE_STEP_CNT_EN
    logic [15:0] step_cnt;
`endif

    always #5 clk = ~clk;

    moore_table_fsm #(.N_STATES(NS), .IN_W(2), .OUT_W(1), .RESET_STATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .ctrl_in(ctrl_in),
        .state_ld(state_ld), .state_in(state_in), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .state(state), .out(out), .err(err)
`ifdef MOORE_STEP_CNT_EN
        , .step_cnt(step_cnt)
`endif
    );

    int n_chk = 0, n_pass = 0;
    int m_st, m_err, m_cnt;
    int m_nxt [NS][4];
    int m_out [NS];

    typedef struct {
        logic ld; logic [1:0] sin; logic ct; logic [1:0] sw;
        logic we; logic sel; logic [3:0] addr; logic [1:0] data;
        int e_st; int e_out; int e_err;
    } vec_t;
    vec_t vt [20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic m_reset();
        m_st = 0; m_err = 0; m_cnt = 0;
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < 4; i++) m_nxt[s][i] = s;
            m_out[s] = 0;
        end
    endtask

    task automatic cyc(input logic ld, input logic [1:0] sin, input logic ct, input logic [1:0] sw,
                       input logic we, input logic sel, input logic [3:0] addr, input logic [1:0] data);
        int row, col, nst;
        bit bad;
        state_ld = ld; state_in = sin; ctrl_in = ct; sw_in = sw;
        cfg_we = we; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        @(posedge clk);
        row = int'(addr) / 4; col = int'(addr) % 4;
        bad = we && (row >= NS || (!sel && int'(data) >= NS));
        nst = m_st;
        if (ld) begin
            if (int'(sin) < NS) begin nst = int'(sin); m_err = 0; end
            else m_err = 1;
            m_cnt = 0;
        end else if (ct) begin
            nst = m_nxt[m_st][int'(sw)];
            if (m_cnt < 65535) m_cnt++;
        end
        if (we && !bad) begin
            if (!sel) m_nxt[row][col] = int'(data);
            else m_out[row] = int'(data) % 2;
        end
        if (bad) m_err = 1;
        m_st = nst;
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_state"}, int'(state), m_st);
        chk({tag, "_out"}, int'(out), m_out[m_st]);
        chk({tag, "_err"}, int'(err), m_err);
`ifdef MOORE_STEP_CNT_EN
        chk({tag, "_cnt"}, int'(step_cnt), m_cnt);
`endif
    endtask

    initial begin
        int tbl [NS][4];
        tbl = '{'{1, 1, 1, 1}, '{1, 0, 2, 2}, '{2, 0, 2, 0}};
        vt[0]  = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
        vt[1]  = '{0, 0, 1, 2, 0, 0, 4'b0000, 0, 2, 1, 0};
        vt[2]  = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 2, 1, 0};
        vt[3]  = '{0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
        vt[5]  = '{0, 0, 1, 2, 1, 0, 4'b0110, 0, 2, 1, 0};
        vt[6]  = '{0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
        vt[8]  = '{0, 0, 1, 2, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[9]  = '{1, 2, 1, 0, 0, 0, 4'b0000, 0, 2, 1, 0};
        vt[10] = '{0, 0, 0, 0, 1, 0, 4'b0000, 3, 2, 1, 1};
        vt[11] = '{1, 3, 0, 0, 0, 0, 4'b0000, 0, 2, 1, 1};
        vt[12] = '{0, 0, 0, 0, 1, 1, 4'b1100, 1, 2, 1, 1};
        vt[13] = '{1, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
        vt[14] = '{0, 0, 0, 0, 1, 1, 4'b0100, 1, 1, 1, 0};
        vt[15] = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[16] = '{1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[17] = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[18] = '{0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[19] = '{1, 0, 0, 0, 1, 1, 4'b0000, 1, 0, 1, 0};

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_out", int'(out), 0);
        chk("reset_err", int'(err), 0);
        @(negedge clk) reset_n = 1'b1;

        // dirty every piece of state, then drop reset_n between edges
        cyc(1, 2, 0, 0, 0, 0, 4'b0000, 0);
        cyc(0, 0, 0, 0, 1, 1, 4'b1000, 1);
        cyc(0, 0, 0, 0, 1, 0, 4'b0000, 3);
        chk_model("pre_rst");
        ctrl_in = 1'b1; sw_in = 2'd1;
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_err", int'(err), 0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 2'(i), 0, 0, 4'b0000, 0);
            chk_model("selfloop");
        end

        for (int s = 0; s < NS; s++)
            for (int i = 0; i < 4; i++)
                cyc(0, 0, 0, 0, 1, 0, 4'(s * 4 + i), 2'(tbl[s][i]));
        cyc(0, 0, 0, 0, 1, 1, 4'b1000, 1);
        chk_model("loaded");

        for (int k = 0; k < 20; k++) begin
            cyc(vt[k].ld, vt[k].sin, vt[k].ct, vt[k].sw, vt[k].we, vt[k].sel, vt[k].addr, vt[k].data);
            chk($sformatf("vec%0d_state", k), int'(state), vt[k].e_st);
            chk($sformatf("vec%0d_out", k), int'(out), vt[k].e_out);
            chk($sformatf("vec%0d_err", k), int'(err), vt[k].e_err);
        end

        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 2'(i), 0, 0, 4'b0000, 0);
            chk("hold_state", int'(state), 0);
            chk("hold_out", int'(out), 1);
        end

`ifdef MOORE_STEP_CNT_EN
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, 0);
        repeat (5) cyc(0, 0, 1, 0, 0, 0, 4'b0000, 0);
        chk("cnt_five", int'(step_cnt), 5);
        cyc(1, 1, 1, 0, 0, 0, 4'b0000, 0);
        chk("cnt_ld_clear", int'(step_cnt), 0);
        repeat (65538) cyc(0, 0, 1, 0, 0, 0, 4'b0000, 0);
        chk("cnt_saturate", int'(step_cnt), 65535);
`endif

        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
